// File: rtl/adc_capture_ctrl.sv
// Two-channel ADC capture controller: arms on CapStart, waits for a software
// or rising-edge level trigger on Ch0, packs CapLen samples into 32-bit words
// and streams them through a small FIFO to an AXI-Stream master port.
module adc_capture_ctrl #(
  parameter int unsigned C_LenWidth  = 24,
  parameter int unsigned C_FifoDepth = 16
) (
  input  logic                  SysSampleClk,
  input  logic                  SysSampleRst_n,
  input  logic                  AdcDataValid,
  input  logic [13:0]           AdcDataCh0,
  input  logic [13:0]           AdcDataCh1,
  input  logic                  CapStart,
  input  logic                  CapAbort,
  input  logic                  CapTrigSw,
  input  logic                  TrigEn,
  input  logic [13:0]           TrigLevel,
  input  logic [C_LenWidth-1:0] CapLen,
  output logic [31:0]           M_AXIS_tdata,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic                  M_AXIS_tlast,
  output logic                  CapBusy,
  output logic                  CapDone,
  output logic                  CapOverflow
);

  localparam int unsigned AW = $clog2(C_FifoDepth);
  // Non-final samples may only fill the FIFO up to depth-1 so the final
  // (tlast) word always has a slot.
  localparam logic [AW:0] FILL_LIMIT = (AW+1)'(C_FifoDepth - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [C_LenWidth-1:0]   len_q, len_d;
  logic [C_LenWidth-1:0]   cnt_q, cnt_d;
  logic [C_LenWidth-1:0]   cnt_inc;
  logic signed [13:0]      level_q, level_d;
  logic signed [13:0]      prev_ch0_q, prev_ch0_d;
  logic                    prev_vld_q, prev_vld_d;
  logic                    trig_sw_q, trig_sw_d;
  logic                    pk_vld_q, pk_vld_d;
  logic                    pk_last_q, pk_last_d;
  logic [31:0]             pk_data_q, pk_data_d;
  logic                    ovf_q, ovf_d;

  logic [32:0]             mem_q [C_FifoDepth];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             fill_q, fill_d;

  logic                    fifo_nempty;
  logic                    fifo_room;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic                    fifo_drop;
  logic [32:0]             rd_word;

  logic [31:0]             sample_word;
  logic                    sw_hit;
  logic                    lvl_hit;
  logic                    sample_last;

  assign sample_word = {{2{AdcDataCh1[13]}}, AdcDataCh1, {2{AdcDataCh0[13]}}, AdcDataCh0};
  assign cnt_inc     = cnt_q + C_LenWidth'(1);

  // A latched software pulse and a pulse arriving with the sample both count.
  assign sw_hit  = trig_sw_q | CapTrigSw;
  assign lvl_hit = TrigEn & prev_vld_q & (prev_ch0_q < level_q) &
                   ($signed(AdcDataCh0) >= level_q);

  // FIFO handshake and write-admission decisions
  assign fifo_nempty = (fill_q != '0);
  assign fifo_room   = (fill_q < FILL_LIMIT);
  assign fifo_rd     = fifo_nempty & M_AXIS_tready;
  assign fifo_wr     = pk_vld_q & ~CapAbort & (pk_last_q | fifo_room);
  assign fifo_drop   = pk_vld_q & ~CapAbort & ~pk_last_q & ~fifo_room;
  assign rd_word     = mem_q[rd_ptr_q];

  // Output port drive; data is forced to zero whenever nothing is queued
  assign M_AXIS_tvalid = fifo_nempty;
  assign M_AXIS_tdata  = fifo_nempty ? rd_word[31:0] : '0;
  assign M_AXIS_tlast  = fifo_nempty & rd_word[32];
  assign CapBusy       = (state_q == ST_ARMED) | (state_q == ST_CAPTURE) |
                         (state_q == ST_DRAIN);
  assign CapDone       = (state_q == ST_DONE);
  assign CapOverflow   = ovf_q;

  // Capture FSM: next state, trigger tracking, sample counting and packing
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    prev_ch0_d  = prev_ch0_q;
    prev_vld_d  = prev_vld_q;
    trig_sw_d   = trig_sw_q;
    pk_vld_d    = 1'b0;
    pk_last_d   = 1'b0;
    pk_data_d   = pk_data_q;
    ovf_d       = ovf_q | fifo_drop;
    sample_last = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (CapAbort) begin
          state_d = ST_IDLE;
        end else if (CapStart) begin
          len_d      = CapLen;
          level_d    = $signed(TrigLevel);
          cnt_d      = '0;
          prev_vld_d = 1'b0;
          trig_sw_d  = 1'b0;
          ovf_d      = 1'b0;
          state_d    = (CapLen == '0) ? ST_DONE : ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (CapAbort) begin
          state_d = ST_IDLE;
        end else begin
          if (CapTrigSw) begin
            trig_sw_d = 1'b1;
          end
          if (AdcDataValid) begin
            prev_vld_d = 1'b1;
            prev_ch0_d = $signed(AdcDataCh0);
            if (sw_hit | lvl_hit) begin
              sample_last = (len_q == C_LenWidth'(1));
              cnt_d       = C_LenWidth'(1);
              pk_vld_d    = 1'b1;
              pk_last_d   = sample_last;
              pk_data_d   = sample_word;
              state_d     = sample_last ? ST_DRAIN : ST_CAPTURE;
            end
          end
        end
      end

      ST_CAPTURE: begin
        if (CapAbort) begin
          state_d = ST_IDLE;
        end else if (AdcDataValid) begin
          sample_last = (cnt_inc == len_q);
          cnt_d       = cnt_inc;
          pk_vld_d    = 1'b1;
          pk_last_d   = sample_last;
          pk_data_d   = sample_word;
          if (sample_last) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (CapAbort) begin
          state_d = ST_IDLE;
        end else if (fifo_rd && rd_word[32]) begin
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous read and write cancel
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
    rd_ptr_d = rd_ptr_q + AW'(fifo_rd);
    fill_d   = fill_q + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
  end

  // Control and status registers
  always_ff @(posedge SysSampleClk or negedge SysSampleRst_n) begin
    if (!SysSampleRst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      prev_ch0_q <= '0;
      prev_vld_q <= 1'b0;
      trig_sw_q  <= 1'b0;
      pk_vld_q   <= 1'b0;
      pk_last_q  <= 1'b0;
      pk_data_q  <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      prev_ch0_q <= prev_ch0_d;
      prev_vld_q <= prev_vld_d;
      trig_sw_q  <= trig_sw_d;
      pk_vld_q   <= pk_vld_d;
      pk_last_q  <= pk_last_d;
      pk_data_q  <= pk_data_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // FIFO storage: {tlast, tdata}; contents are only observed when occupied
  always_ff @(posedge SysSampleClk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {pk_last_q, pk_data_q};
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: scoreboard of expected stream
// beats plus directed sequences for trigger, backpressure, abort and reset.
module tb_adc_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [13:0] ch0;
  logic [13:0] ch1;
  logic        cap_start;
  logic        cap_abort;
  logic        trig_sw;
  logic        trig_en;
  logic [13:0] trig_level;
  logic [23:0] cap_len;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        busy;
  logic        done;
  logic        ovf;

  adc_capture_ctrl #(.C_LenWidth(24), .C_FifoDepth(16)) dut (
    .SysSampleClk   (clk),
    .SysSampleRst_n (rst_n),
    .AdcDataValid   (valid),
    .AdcDataCh0     (ch0),
    .AdcDataCh1     (ch1),
    .CapStart       (cap_start),
    .CapAbort       (cap_abort),
    .CapTrigSw      (trig_sw),
    .TrigEn         (trig_en),
    .TrigLevel      (trig_level),
    .CapLen         (cap_len),
    .M_AXIS_tdata   (tdata),
    .M_AXIS_tvalid  (tvalid),
    .M_AXIS_tready  (tready),
    .M_AXIS_tlast   (tlast),
    .CapBusy        (busy),
    .CapDone        (done),
    .CapOverflow    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [13:0] ch0;
    logic [13:0] ch1;
    logic [31:0] exp;
  } vec_t;

  beat_t       sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          beats = 0;
  logic        last_tlast = 1'b0;
  logic        sb_en = 1'b1;
  logic        stall_q = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid     = 1'b0;
    cap_start = 1'b0;
    cap_abort = 1'b0;
    trig_sw   = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max, input string name);
    int unsigned n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic start_cap(input logic [23:0] len);
    cap_len   = len;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  // Stream monitor: scoreboard compare on handshake, stall stability check
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        chk("stall_tvalid", tvalid, 1'b1);
        chk("stall_tdata", tdata, stall_data);
        chk("stall_tlast", tlast, stall_last);
      end
      if (tvalid && tready) begin
        beats++;
        last_tlast = tlast;
        if (sb_en) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", sb_q.size(), 1);
          end else begin
            beat_t e;
            e = sb_q.pop_front();
            chk("beat_data", tdata, e.data);
            chk("beat_last", tlast, e.last);
          end
        end
      end
      stall_q    = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{14'h2000, 14'h1FFF, 32'h1FFF_E000};
    vecs[1] = '{14'h0000, 14'h0000, 32'h0000_0000};
    vecs[2] = '{14'h3FFF, 14'h0001, 32'h0001_FFFF};
    vecs[3] = '{14'h0069, 14'h3F9C, 32'hFF9C_0069};
    vecs[4] = '{14'h1000, 14'h2001, 32'hE001_1000};

    clear_inputs();
    rst_n      = 1'b0;
    trig_en    = 1'b0;
    trig_level = '0;
    cap_len    = '0;
    ch0        = '0;
    ch1        = '0;
    tready     = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    tick();

    // Packing / sign extension: one-sample captures from the vector table
    for (int i = 0; i < 5; i++) begin
      beats = 0;
      start_cap(24'd1);
      chk("vec_busy", busy, 1'b1);
      valid   = 1'b1;
      trig_sw = 1'b1;
      ch0     = vecs[i].ch0;
      ch1     = vecs[i].ch1;
      sb_q.push_back('{vecs[i].exp, 1'b1});
      tick();
      clear_inputs();
      wait_done(20, "vec_done");
      tick();
      chk("vec_beats", beats, 1);
      chk("vec_ovf", ovf, 1'b0);
    end

    // Software trigger, length 4, with CapLen changed and CapStart re-pulsed
    beats = 0;
    start_cap(24'd4);
    cap_len = 24'd99;
    for (int k = 0; k < 8; k++) begin
      valid     = 1'b1;
      ch0       = 14'(10 + k);
      ch1       = 14'(200 + k);
      trig_sw   = (k == 0);
      cap_start = (k == 1);
      if (k < 4) sb_q.push_back('{{16'(200 + k), 16'(10 + k)}, (k == 3)});
      tick();
    end
    clear_inputs();
    wait_done(20, "sw_done");
    tick();
    chk("sw_beats", beats, 4);
    chk("sw_last_tlast", last_tlast, 1'b1);
    chk("sw_ovf", ovf, 1'b0);
    chk("sw_busy", busy, 1'b0);
    chk("sw_sb_empty", sb_q.size(), 0);

    // Level trigger on a rising crossing of +100
    begin
      logic [13:0] ramp[5];
      ramp = '{14'd90, 14'd95, 14'd105, 14'd110, 14'd120};
      beats      = 0;
      trig_en    = 1'b1;
      trig_level = 14'd100;
      start_cap(24'd2);
      trig_level = 14'd0;
      ch1 = '0;
      sb_q.push_back('{32'h0000_0069, 1'b0});
      sb_q.push_back('{32'h0000_006E, 1'b1});
      for (int k = 0; k < 5; k++) begin
        valid = 1'b1;
        ch0   = ramp[k];
        tick();
      end
      clear_inputs();
      wait_done(20, "lvl_done");
      tick();
      chk("lvl_beats", beats, 2);
    end

    // Signed level -5: first sample above level must not trigger
    begin
      logic [13:0] seq[4];
      seq = '{14'd120, 14'h3FF0, 14'd2, 14'd3};
      beats      = 0;
      trig_level = 14'h3FFB;
      start_cap(24'd1);
      sb_q.push_back('{32'h0000_0002, 1'b1});
      for (int k = 0; k < 4; k++) begin
        valid = 1'b1;
        ch0   = seq[k];
        tick();
      end
      clear_inputs();
      wait_done(20, "slvl_done");
      tick();
      chk("slvl_beats", beats, 1);
      trig_en = 1'b0;
    end

    // Backpressure: 40 samples into a 16-deep FIFO with a 30-cycle stall
    sb_en  = 1'b0;
    beats  = 0;
    tready = 1'b0;
    start_cap(24'd40);
    for (int k = 0; k < 40; k++) begin
      valid   = 1'b1;
      ch0     = 14'(k);
      ch1     = 14'(k + 1000);
      trig_sw = (k == 0);
      if (k == 30) tready = 1'b1;
      tick();
    end
    clear_inputs();
    wait_done(200, "bp_done");
    tick();
    chk("bp_ovf", ovf, 1'b1);
    chk("bp_beats_le_40", (beats <= 40), 1'b1);
    chk("bp_last_tlast", last_tlast, 1'b1);
    sb_en = 1'b1;

    // Abort with three words queued
    beats  = 0;
    tready = 1'b0;
    start_cap(24'd20);
    chk("abort_ovf_cleared", ovf, 1'b0);
    for (int k = 0; k < 3; k++) begin
      valid   = 1'b1;
      ch0     = 14'(k + 1);
      ch1     = 14'h3FFE;
      trig_sw = (k == 0);
      sb_q.push_back('{{16'hFFFE, 16'(k + 1)}, 1'b0});
      tick();
    end
    clear_inputs();
    repeat (2) tick();
    cap_abort = 1'b1;
    valid     = 1'b1;
    ch0       = 14'd77;
    tick();
    cap_abort = 1'b0;
    repeat (2) tick();
    valid = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    tready = 1'b1;
    repeat (10) tick();
    chk("abort_beats", beats, 3);
    chk("abort_sb_empty", sb_q.size(), 0);
    chk("abort_tvalid", tvalid, 1'b0);

    // Abort wins over a simultaneous trigger
    beats = 0;
    start_cap(24'd5);
    cap_abort = 1'b1;
    trig_sw   = 1'b1;
    valid     = 1'b1;
    tick();
    clear_inputs();
    repeat (6) tick();
    chk("abtrig_beats", beats, 0);
    chk("abtrig_busy", busy, 1'b0);

    // Zero length goes straight to DONE
    beats = 0;
    start_cap(24'd0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      valid   = 1'b1;
      trig_sw = 1'b1;
      tick();
    end
    clear_inputs();
    repeat (4) tick();
    chk("zero_beats", beats, 0);

    // Reset asserted mid-capture
    sb_en  = 1'b0;
    tready = 1'b0;
    start_cap(24'd10);
    for (int k = 0; k < 3; k++) begin
      valid   = 1'b1;
      ch0     = 14'(k + 5);
      trig_sw = (k == 0);
      tick();
    end
    clear_inputs();
    repeat (2) tick();
    chk("rstcap_pre_tvalid", tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstcap_tvalid", tvalid, 1'b0);
    chk("rstcap_tlast", tlast, 1'b0);
    chk("rstcap_tdata", tdata, 32'h0);
    chk("rstcap_busy", busy, 1'b0);
    chk("rstcap_done", done, 1'b0);
    chk("rstcap_ovf", ovf, 1'b0);
    tick();
    rst_n  = 1'b1;
    beats  = 0;
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      valid   = 1'b1;
      trig_sw = 1'b1;
      tick();
    end
    clear_inputs();
    repeat (5) tick();
    chk("postrst_beats", beats, 0);
    chk("postrst_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
